// File: rtl/dcache_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int BLOCK_W    = 128;
  localparam int MEM_ADDR_W = 28;
  localparam int OFFSET_W   = 4;
  localparam int WORD_SEL_W = 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
endpackage

// File: rtl/dcache_word_merge.sv
// Combinational word path: 4:1 word select for reads, byte-enable merge of store data into a line.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [BLOCK_W-1:0]    i_line,
  input  logic [WORD_SEL_W-1:0] i_word_sel,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_byte_en,
  output logic [31:0]           o_rdata,
  output logic [BLOCK_W-1:0]    o_line
);
  always_comb begin
    o_rdata = i_line[int'(i_word_sel)*32 +: 32];
    o_line  = i_line;
    for (int b = 0; b < 4; b++) begin
      if (i_byte_en[b]) o_line[int'(i_word_sel)*32 + b*8 +: 8] = i_wdata[b*8 +: 8];
    end
  end
endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped write-back/write-allocate D-cache: hits in 0 cycles, misses stall via CPU_BUSYWAIT.
// Defining DCACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_wb_dm
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 25
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  CPU_READ,
  input  logic                  CPU_WRITE,
  input  logic [31:0]           CPU_ADDRESS,
  input  logic [31:0]           CPU_WRITEDATA,
  input  logic [3:0]            CPU_BYTE_EN,
  output logic [31:0]           CPU_READDATA,
  output logic                  CPU_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           HIT_COUNT,
  output logic [31:0]           MISS_COUNT
`endif
);
  state_t                r_state, w_next;
  logic [NUM_SETS-1:0]   r_valid, r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_SETS];
  logic [BLOCK_W-1:0]    r_data [NUM_SETS];
  logic [BLOCK_W-1:0]    r_refill;
  logic [31:0]           r_rdata;
  logic                  r_mem_read, r_mem_write;
  logic [MEM_ADDR_W-1:0] r_mem_addr;
  logic [BLOCK_W-1:0]    r_mem_wdata;

  logic [WORD_SEL_W-1:0] w_word;
  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_access, w_hit, w_rd_hit, w_wr_hit;
  logic [BLOCK_W-1:0]    w_line, w_merged;
  logic [31:0]           w_word_data;
  logic                  w_unused;

  assign w_word   = CPU_ADDRESS[OFFSET_W-1:2];
  assign w_idx    = CPU_ADDRESS[OFFSET_W+IDX_W-1:OFFSET_W];
  assign w_tag    = CPU_ADDRESS[31:OFFSET_W+IDX_W];
  assign w_unused = ^CPU_ADDRESS[1:0];
  assign w_access = CPU_READ ^ CPU_WRITE;
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line   = r_data[w_idx];

  dcache_word_merge u_merge (
    .i_line     (w_line),
    .i_word_sel (w_word),
    .i_wdata    (CPU_WRITEDATA),
    .i_byte_en  (CPU_BYTE_EN),
    .o_rdata    (w_word_data),
    .o_line     (w_merged)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_access && !w_hit)
                   w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (!MEM_BUSYWAIT) w_next = ALLOCATE;
      ALLOCATE:  if (!MEM_BUSYWAIT) w_next = REFILL;
      REFILL:    w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rd_hit      = (r_state == IDLE) && w_access && w_hit && CPU_READ;
    w_wr_hit      = (r_state == IDLE) && w_access && w_hit && CPU_WRITE;
    CPU_BUSYWAIT  = (r_state != IDLE) || (w_access && !w_hit);
    CPU_READDATA  = w_rd_hit ? w_word_data : r_rdata;
    MEM_READ      = r_mem_read;
    MEM_WRITE     = r_mem_write;
    MEM_ADDRESS   = r_mem_addr;
    MEM_WRITEDATA = r_mem_wdata;
  end

  // Memory strobes are registered from the next state so they never glitch and drop the cycle after completion.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_mem_read  <= (w_next == ALLOCATE);
      r_mem_write <= (w_next == WRITEBACK);
      if (r_state == IDLE && w_next == WRITEBACK) begin
        r_mem_addr  <= {r_tag[w_idx], w_idx};
        r_mem_wdata <= w_line;
      end else if (w_next == ALLOCATE && r_state != ALLOCATE) begin
        r_mem_addr  <= CPU_ADDRESS[31:OFFSET_W];
      end
      if (w_rd_hit) r_rdata <= w_word_data;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == REFILL) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (r_state == REFILL) begin
      r_data[w_idx] <= r_refill;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx] <= w_merged;
    end
    if (r_state == ALLOCATE && !MEM_BUSYWAIT) r_refill <= MEM_READDATA;
  end

`ifdef DCACHE_STATS_EN
  logic        r_post_refill;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // The hit that completes a refilled miss is part of that miss, not a separate hit.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_post_refill <= 1'b0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      r_post_refill <= (r_state == REFILL);
      if (r_state == IDLE && w_access && w_hit && !r_post_refill && r_hit_cnt != '1)
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (r_state == IDLE && w_next != IDLE && r_miss_cnt != '1)
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign HIT_COUNT  = r_hit_cnt;
  assign MISS_COUNT = r_miss_cnt;
`endif
endmodule

// File: tb/tb_dcache_wb_dm.sv
// Randomized scoreboard bench for dcache_wb_dm against a flat-memory reference and a 16-cycle memory model.
module tb_dcache_wb_dm;
  logic         CLOCK = 1'b0;
  logic         RESET = 1'b0;
  logic         CPU_READ = 1'b0, CPU_WRITE = 1'b0;
  logic [31:0]  CPU_ADDRESS = '0, CPU_WRITEDATA = '0;
  logic [3:0]   CPU_BYTE_EN = '0;
  logic [31:0]  CPU_READDATA;
  logic         CPU_BUSYWAIT;
  logic         MEM_READ, MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

  always #5 CLOCK = ~CLOCK;

  dcache_wb_dm dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .CPU_READ(CPU_READ), .CPU_WRITE(CPU_WRITE), .CPU_ADDRESS(CPU_ADDRESS),
    .CPU_WRITEDATA(CPU_WRITEDATA), .CPU_BYTE_EN(CPU_BYTE_EN),
    .CPU_READDATA(CPU_READDATA), .CPU_BUSYWAIT(CPU_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Backing store (what memory holds) and architectural view (what the CPU must observe).
  logic [127:0] bmem [256];
  logic [127:0] amem [256];
  bit           res_vld   [8];
  bit           res_dirty [8];
  logic [7:0]   res_blk   [8];

  typedef struct packed {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] dat;
  } mev_t;
  mev_t        mem_q[$];
  logic [31:0] rd_q[$];

  int       mcnt  = 0;
  logic     mdone = 1'b0;
  logic [1:0] mkind = 2'b00;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) & ~mdone;

  // Memory model and memory-side monitor: each transfer completes after 16 busy cycles.
  always @(negedge CLOCK) begin
    mev_t e;
    if ({MEM_READ, MEM_WRITE} != mkind) begin
      mkind = {MEM_READ, MEM_WRITE};
      mcnt  = 0;
      mdone = 1'b0;
    end
    if (mkind != 2'b00 && !mdone) begin
      mcnt++;
      if (mcnt == 16) begin
        mdone = 1'b1;
        chk("mem_rd_wr_exclusive", 128'(MEM_READ & MEM_WRITE), 128'd0);
        if (mem_q.size() == 0) note_fail("mem_unexpected_transfer");
        else begin
          e = mem_q.pop_front();
          chk("mem_kind", 128'(MEM_WRITE), 128'(e.wr));
          chk("mem_addr", 128'(MEM_ADDRESS), 128'(e.addr));
          if (MEM_WRITE) chk("wb_data", MEM_WRITEDATA, e.dat);
        end
        if (MEM_WRITE) bmem[MEM_ADDRESS[7:0]] = MEM_WRITEDATA;
        else           MEM_READDATA = bmem[MEM_ADDRESS[7:0]];
      end
    end
  end

  // CPU-side monitor: a read completes on the cycle the cache stops stalling.
  always @(negedge CLOCK) begin
    if (RESET && CPU_READ && !CPU_WRITE && !CPU_BUSYWAIT) begin
      if (rd_q.size() == 0) note_fail("rd_unexpected");
      else chk("rdata", 128'(CPU_READDATA), 128'(rd_q.pop_front()));
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    int blk, set, w;
    blk = int'(a[11:4]);
    set = blk % 8;
    w   = int'(a[3:2]);
    if (rd ^ wr) begin
      if (!(res_vld[set] && res_blk[set] == 8'(blk))) begin
        if (res_vld[set] && res_dirty[set])
          mem_q.push_back(mev_t'{wr: 1'b1, addr: 28'(res_blk[set]), dat: amem[res_blk[set]]});
        mem_q.push_back(mev_t'{wr: 1'b0, addr: 28'(blk), dat: 128'd0});
        res_vld[set]   = 1'b1;
        res_blk[set]   = 8'(blk);
        res_dirty[set] = 1'b0;
      end
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) amem[blk][w*32 + b*8 +: 8] = d[b*8 +: 8];
        res_dirty[set] = 1'b1;
      end else begin
        rd_q.push_back(amem[blk][w*32 +: 32]);
      end
    end
    CPU_READ = rd; CPU_WRITE = wr; CPU_ADDRESS = a; CPU_WRITEDATA = d; CPU_BYTE_EN = be;
  endtask

  task automatic finish_access(input string name);
    int n = 0;
    @(negedge CLOCK);
    while (CPU_BUSYWAIT && n < 200) begin
      @(negedge CLOCK);
      n++;
    end
    if (CPU_BUSYWAIT) note_fail({name, "_stall_timeout"});
    @(posedge CLOCK); #1;
    CPU_READ = 1'b0; CPU_WRITE = 1'b0;
  endtask

  task automatic wait_mem(input bit want_wr, input int bound, input string name);
    int n = 0;
    @(negedge CLOCK);
    while (!(want_wr ? MEM_WRITE : MEM_READ) && n < bound) begin
      @(negedge CLOCK);
      n++;
    end
    if (!(want_wr ? MEM_WRITE : MEM_READ)) note_fail({name, "_req_timeout"});
  endtask

  task automatic model_reset();
    mem_q.delete();
    rd_q.delete();
    for (int i = 0; i < 256; i++) amem[i] = bmem[i];
    for (int s = 0; s < 8; s++) begin res_vld[s] = 1'b0; res_dirty[s] = 1'b0; end
  endtask

  initial begin
    logic [127:0] blk4;
    for (int i = 0; i < 256; i++)
      bmem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int j = 0; j < 16; j++) blk4[j*8 +: 8] = 8'(j);
    bmem[4] = blk4;
    model_reset();

    #1;
    chk("rst_mem_read",   128'(MEM_READ), 128'd0);
    chk("rst_mem_write",  128'(MEM_WRITE), 128'd0);
    chk("rst_mem_addr",   128'(MEM_ADDRESS), 128'd0);
    chk("rst_mem_wdata",  MEM_WRITEDATA, 128'd0);
    chk("rst_cpu_rdata",  128'(CPU_READDATA), 128'd0);
    chk("rst_cpu_busy",   128'(CPU_BUSYWAIT), 128'd0);
    @(negedge CLOCK); RESET = 1'b1;
    @(posedge CLOCK); #1;

    // Clean miss on block 4.
    issue(1, 0, 32'h0000_0040, 32'h0, 4'h0);
    wait_mem(0, 5, "first_alloc");
    chk("first_miss_busy",  128'(CPU_BUSYWAIT), 128'd1);
    chk("first_alloc_addr", 128'(MEM_ADDRESS), 128'h4);
    finish_access("first_read");
    chk("first_read_data", 128'(CPU_READDATA), 128'h0302_0100);

    // Write hit, partial bytes.
    issue(0, 1, 32'h0000_0044, 32'hDEAD_BEEF, 4'b0011);
    finish_access("write_hit");
    chk("write_hit_no_mem", 128'(MEM_READ | MEM_WRITE), 128'd0);
    issue(1, 0, 32'h0000_0044, 32'h0, 4'h0);
    finish_access("read_back");
    chk("read_back_data", 128'(CPU_READDATA), 128'h0706_BEEF);

    // Conflict miss forces writeback of the dirty line.
    issue(1, 0, 32'h0000_00C0, 32'h0, 4'h0);
    wait_mem(1, 5, "conflict_wb");
    chk("wb_addr",  128'(MEM_ADDRESS), 128'h4);
    chk("wb_word1", 128'(MEM_WRITEDATA[63:32]), 128'h0706_BEEF);
    wait_mem(0, 40, "conflict_alloc");
    chk("conflict_alloc_addr", 128'(MEM_ADDRESS), 128'hC);
    finish_access("conflict");

    // Both strobes high is not an access.
    issue(1, 1, 32'h0000_00C0, 32'h1234_5678, 4'hF);
    @(negedge CLOCK);
    chk("both_high_busy", 128'(CPU_BUSYWAIT), 128'd0);
    chk("both_high_no_mem", 128'(MEM_READ | MEM_WRITE), 128'd0);
    @(posedge CLOCK); #1;
    CPU_READ = 1'b0; CPU_WRITE = 1'b0;
`ifdef DCACHE_STATS_EN
    chk("hit_count",  128'(HIT_COUNT), 128'd2);
    chk("miss_count", 128'(MISS_COUNT), 128'd2);
`endif
    issue(1, 0, 32'h0000_00C0, 32'h0, 4'h0);
    finish_access("both_high_after");
    chk("both_high_line_kept", 128'(CPU_READDATA), 128'(amem[12][31:0]));

    // Reset in the middle of a refill fetch.
    issue(1, 0, 32'h0000_0200, 32'h0, 4'h0);
    wait_mem(0, 5, "reset_alloc");
    @(negedge CLOCK);
    RESET = 1'b0; CPU_READ = 1'b0;
    #1;
    chk("reset_drops_mem_read", 128'(MEM_READ), 128'd0);
    chk("reset_busy", 128'(CPU_BUSYWAIT), 128'd0);
    model_reset();
    @(negedge CLOCK); RESET = 1'b1;
    @(posedge CLOCK); #1;
    issue(1, 0, 32'h0000_0044, 32'h0, 4'h0);
    @(negedge CLOCK);
    chk("post_reset_miss", 128'(CPU_BUSYWAIT), 128'd1);
    finish_access("post_reset");
    chk("post_reset_data", 128'(CPU_READDATA), 128'h0706_BEEF);

    // Random traffic over 32 blocks (four tags per set).
    for (int k = 0; k < 400; k++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      a  = {20'd0, 8'($urandom_range(0, 31)), 4'($urandom())};
      if (op == 0) begin
        issue(1, 1, a, $urandom(), 4'($urandom()));
        @(negedge CLOCK);
        chk("rand_both_busy", 128'(CPU_BUSYWAIT), 128'd0);
        @(posedge CLOCK); #1;
        CPU_READ = 1'b0; CPU_WRITE = 1'b0;
      end else if (op <= 4) begin
        issue(0, 1, a, $urandom(), 4'($urandom()));
        finish_access("rand_write");
      end else begin
        issue(1, 0, a, 32'h0, 4'h0);
        finish_access("rand_read");
      end
    end

    repeat (2) @(posedge CLOCK);
    chk("rd_q_drained",  128'(rd_q.size()), 128'd0);
    chk("mem_q_drained", 128'(mem_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/dcache_wb_dm.md
Name: dcache_wb_dm

Overview:
Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and data_memory (128-bit block interface, 28-bit block address, BUSYWAIT handshake).
- CPU side: 32-bit word accesses with byte enables.
- Memory side: one 16-byte block per transaction.
- Hits complete combinationally in the same cycle. Misses stall the CPU through CPU_BUSYWAIT.

Parameters:
- NUM_SETS, 8, number of cache lines; power of two, ≥2.
- IDX_W, 3, log2(NUM_SETS).
- TAG_W, 25, 28 − IDX_W.

Ports:
- CLOCK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- CPU_READ  in  1  read request.
- CPU_WRITE  in  1  write request.
- CPU_ADDRESS  in  32  byte address; [3:2] word, [3+IDX_W:4] index, [31:4+IDX_W] tag; [1:0] ignored.
- CPU_WRITEDATA  in  32  store data.
- CPU_BYTE_EN  in  4  per-byte write enable; ignored on reads.
- CPU_READDATA  out  32  selected word.
- CPU_BUSYWAIT  out  1  stall; CPU holds all request inputs stable while high.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block writeback request.
- MEM_ADDRESS  out  28  block address.
- MEM_WRITEDATA  out  128  victim block.
- MEM_READDATA  in  128  fetched block; byte 0 in [7:0].
- MEM_BUSYWAIT  in  1  memory busy; low marks the transfer complete.

Behaviour:
- Per line storage: valid, dirty, tag[TAG_W], data[128].
- hit = valid[idx] & (tag[idx] == addr tag).
- Reset (RESET low, asynchronous):
  - all valid and dirty bits cleared; state = IDLE.
  - MEM_READ = MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0, CPU_READDATA = 0, CPU_BUSYWAIT = 0.
  - Reset mid-transfer aborts it; dirty data is discarded.
- Request qualification:
  - access = CPU_READ xor CPU_WRITE.
  - Both high, or both low: no access, CPU_BUSYWAIT = 0, no state change.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE:
  - Access and hit:
    - CPU_BUSYWAIT = 0.
    - Read: CPU_READDATA = data word[addr[3:2]], combinational, 0-cycle latency.
    - Write: enabled bytes merged into the line at the next edge; dirty set.
  - Access and miss: CPU_BUSYWAIT = 1 combinationally.
    - Next state WRITEBACK if valid & dirty, else ALLOCATE.
- WRITEBACK:
  - MEM_WRITE = 1, MEM_ADDRESS = {stored tag, idx}, MEM_WRITEDATA = stored line.
  - On an edge with MEM_BUSYWAIT == 0: go to ALLOCATE.
- ALLOCATE:
  - MEM_READ = 1, MEM_ADDRESS = CPU_ADDRESS[31:4].
  - On an edge with MEM_BUSYWAIT == 0: capture MEM_READDATA into a refill register; go to REFILL.
- REFILL:
  - Memory requests deasserted.
  - Edge: line data = refill register, tag written, valid = 1, dirty = 0; go to IDLE.
  - The held request then hits in IDLE (a write hit sets dirty at that point).
- CPU_BUSYWAIT = 1 throughout WRITEBACK, ALLOCATE and REFILL.
- MEM_READ and MEM_WRITE:
  - Never both high.
  - Registered off the state; glitch-free.
  - Deasserted the cycle after completion, so data_memory's counter re-arms.
- Read-data gating: CPU_READDATA holds its last value when not a read hit. It must not be used while CPU_BUSYWAIT is high.
- Miss timing: one complete memory transfer costs 16 memory-busy cycles.
  - Clean miss: roughly 16 + 2 cycles of stall.
  - Dirty miss: roughly 2×16 + 2 cycles of stall.
- CPU_BYTE_EN == 0 on a write hit: tag and line data unchanged, but dirty is still set.
- Index wrap: distinct tags mapping to the same index evict each other.

Optional Feature:
Macro DCACHE_STATS_EN.
- Defined: extra output ports HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - Hits: increment once per IDLE hit (the post-REFILL hit is not counted).
  - Misses: increment once per IDLE→WRITEBACK or IDLE→ALLOCATE transition.
  - Both saturate at all-ones; reset to 0.
- Undefined: ports and counters absent; functionality otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - state enum: IDLE, WRITEBACK, ALLOCATE, REFILL;
  - constants: BLOCK_W = 128, MEM_ADDR_W = 28, OFFSET_W = 4, WORD_SEL_W = 2.
- One sub-module, dcache_word_merge (combinational), performs two functions:
  - 4:1 word select for reads;
  - byte-enable merge of 32-bit store data into a 128-bit line for writes.

Test Plan:
- Reset, then read 0x0000_0040 with memory block 0x40>>4 = 0x004 = 128'h…0F0E_0D0C_0B0A_0908_0706_0504_0302_0100:
  - MEM_READ high with MEM_ADDRESS = 28'h4;
  - after refill, CPU_READDATA = 32'h0302_0100 and CPU_BUSYWAIT falls.
- Write hit to 0x44, data 32'hDEAD_BEEF, CPU_BYTE_EN = 4'b0011:
  - no memory traffic;
  - a subsequent read of 0x44 returns 32'h0706_BEEF.
- Conflict read of 0x0000_00C0 (same index, new tag):
  - WRITEBACK first, with MEM_ADDRESS = 28'h4 and MEM_WRITEDATA word1 = 32'h0706_BEEF;
  - then ALLOCATE with MEM_ADDRESS = 28'hC.
- CPU_READ and CPU_WRITE both high: CPU_BUSYWAIT = 0, no memory request, no line change.
- RESET asserted during ALLOCATE:
  - MEM_READ drops immediately;
  - a subsequent read of 0x44 misses (valid cleared).
- With DCACHE_STATS_EN defined, after the sequence above: HIT_COUNT = 2, MISS_COUNT = 2.
